res_ram_arbiter: RTL and testbench

- Shares the single-port 16384x8 result RAM (res_*) between two requesters.
  - Port A: DT engine, which has priority.
  - Port B: host load/readback port.
- Per-cycle arbitration, atomic lock sequences for A's neighbour-fetch bursts, starvation protection for B, and read-return routing.
- Sits between the DT core/host interface and the result RAM model.

---
 rtl/res_ram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_res_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_ram_arbiter.sv
// res_ram_arbiter: shares the single-port 16384x8 result RAM between the DT
// engine (port A, priority) and the host load/readback port (port B).
// Per-cycle arbitration, lock sequences, starvation relief for B and in-order
// read-return routing. Define ARB_STATS_EN to build the grant/conflict counters;
// without it the stat_* ports are tied to zero.
module res_ram_arbiter #(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned RD_LAT     = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic        a_lock,
   input  logic [13:0] a_addr,
   input  logic [7:0]  a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [7:0]  a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic        b_lock,
   input  logic [13:0] b_addr,
   input  logic [7:0]  b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [7:0]  b_rdata,
   output logic        res_wr,
   output logic        res_rd,
   output logic [13:0] res_addr,
   output logic [7:0]  res_do,
   input  logic [7:0]  res_di,
   output logic        busy,
   output logic [15:0] stat_a_gnt,
   output logic [15:0] stat_b_gnt,
   output logic [15:0] stat_conflict
);

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
   localparam bit LAT1 = (RD_LAT != 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          arb_idle, a_win, b_win;

   logic          acc_vld, acc_we;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;

   logic          res_wr_q, res_rd_q, rd_tag_q;
   logic [AW-1:0] res_addr_q;
   logic [DW-1:0] res_do_q;
   logic          p1_vld_q, p1_tag_q;
   logic          ret_vld, ret_tag;
   logic          a_rvalid_q, b_rvalid_q;
   logic [DW-1:0] a_rdata_q, b_rdata_q;

   // Arbitration: owner-only while locked, otherwise A first unless B is starved
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      a_win    = 1'b0;
      b_win    = 1'b0;
      arb_idle = !((state_q == OWN_A && a_lock) || (state_q == OWN_B && b_lock));
      if (arb_idle) begin
         if (b_req && (!a_req || starve_q >= STARVE_LIM)) b_win = 1'b1;
         else if (a_req)                                  a_win = 1'b1;
      end else if (state_q == OWN_A) begin
         a_win = a_req;
      end else begin
         b_win = b_req;
      end
      if (reset) begin
         a_win = 1'b0;
         b_win = 1'b0;
      end
      if (arb_idle) begin
         if (b_win && b_lock)      state_d = OWN_B;
         else if (a_win && a_lock) state_d = OWN_A;
         else                      state_d = IDLE;
      end
      if (b_win)                                    starve_d = '0;
      else if (arb_idle && b_req && starve_q != '1) starve_d = starve_q + CW'(1);
   end

   // Ownership state and starvation counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   assign acc_vld   = a_win | b_win;
   assign acc_we    = b_win ? b_we    : a_we;
   assign acc_addr  = b_win ? b_addr  : a_addr;
   assign acc_wdata = b_win ? b_wdata : a_wdata;

   // Launch the accepted access onto the RAM pins; address/data hold when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         res_wr_q   <= 1'b0;
         res_rd_q   <= 1'b0;
         res_addr_q <= '0;
         res_do_q   <= '0;
         rd_tag_q   <= 1'b0;
      end else begin
         res_wr_q <= acc_vld & acc_we;
         res_rd_q <= acc_vld & ~acc_we;
         if (acc_vld) begin
            res_addr_q <= acc_addr;
            res_do_q   <= acc_wdata;
            rd_tag_q   <= b_win;
         end
      end
   end

   // Extra tag stage covering one cycle of RAM read latency
   always_ff @(posedge clk) begin
      if (reset) begin
         p1_vld_q <= 1'b0;
         p1_tag_q <= 1'b0;
      end else begin
         p1_vld_q <= LAT1 & res_rd_q;
         p1_tag_q <= rd_tag_q;
      end
   end

   assign ret_vld = LAT1 ? p1_vld_q : res_rd_q;
   assign ret_tag = LAT1 ? p1_tag_q : rd_tag_q;

   // Capture returning read data and steer it to the owning port
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= ret_vld & ~ret_tag;
         b_rvalid_q <= ret_vld & ret_tag;
         if (ret_vld && !ret_tag) a_rdata_q <= res_di;
         if (ret_vld && ret_tag)  b_rdata_q <= res_di;
      end
   end

   assign a_gnt    = a_win;
   assign b_gnt    = b_win;
   assign res_wr   = res_wr_q;
   assign res_rd   = res_rd_q;
   assign res_addr = res_addr_q;
   assign res_do   = res_do_q;
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = (state_q != IDLE) | res_rd_q | p1_vld_q;

`ifdef ARB_STATS_EN
   localparam int unsigned SW = 16;
   logic [SW-1:0] st_a_q, st_b_q, st_c_q;

   // Saturating grant and conflict statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         st_a_q <= '0;
         st_b_q <= '0;
         st_c_q <= '0;
      end else begin
         if (a_win && st_a_q != '1)          st_a_q <= st_a_q + SW'(1);
         if (b_win && st_b_q != '1)          st_b_q <= st_b_q + SW'(1);
         if (a_req && b_req && st_c_q != '1) st_c_q <= st_c_q + SW'(1);
      end
   end

   assign stat_a_gnt    = st_a_q;
   assign stat_b_gnt    = st_b_q;
   assign stat_conflict = st_c_q;
`else
   assign stat_a_gnt    = '0;
   assign stat_b_gnt    = '0;
   assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Testbench for res_ram_arbiter: vector table, hand-written lock/interleave/reset
// sequences and a randomized run, all checked against a cycle-level reference model.
module tb_res_ram_arbiter;
   localparam int unsigned SM    = 8;
   localparam int unsigned RDL   = 0;
   localparam int unsigned DEPTH = 16384;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [13:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [7:0]  a_rdata, b_rdata;
   logic        res_wr, res_rd, busy;
   logic [13:0] res_addr;
   logic [7:0]  res_do, res_di;
   logic [15:0] stat_a_gnt, stat_b_gnt, stat_conflict;

   always #5 clk = ~clk;

   res_ram_arbiter #(.STARVE_MAX(SM), .RD_LAT(RDL)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr), .res_do(res_do), .res_di(res_di),
      .busy(busy), .stat_a_gnt(stat_a_gnt), .stat_b_gnt(stat_b_gnt), .stat_conflict(stat_conflict)
   );

   function automatic logic [7:0] init_val(int i);
      return 8'((i * 37 + 11) ^ (i >> 6));
   endfunction

   // RAM model: unwritten locations read back their initial pattern
   logic [7:0] ram [DEPTH];
   bit         written [DEPTH];
   logic [7:0] ram_rd;
   always @(posedge clk) if (res_wr) begin
      ram[res_addr]     <= res_do;
      written[res_addr] <= 1'b1;
   end
   assign ram_rd = written[res_addr] ? ram[res_addr] : init_val(int'(res_addr));
   generate
      if (RDL == 0) begin : g_lat0
         assign res_di = ram_rd;
      end else begin : g_lat1
         logic [7:0] q = '0;
         always @(posedge clk) if (res_rd) q <= ram_rd;
         assign res_di = q;
      end
   endgenerate

   typedef struct {
      logic rst;
      logic a_req, a_we, a_lock; logic [13:0] a_addr; logic [7:0] a_wd;
      logic b_req, b_we, b_lock; logic [13:0] b_addr; logic [7:0] b_wd;
   } in_t;

   typedef struct {
      in_t  stim;
      logic e_ag, e_bg, e_rd, e_wr, e_arv, e_brv;
      logic [7:0] e_rdata;
   } vec_t;

   typedef struct { int due; bit port; logic [7:0] data; } ret_t;

   // Reference model state
   ret_t        m_pend[$];
   int          cyc, m_owner, m_starve, m_sa, m_sb, m_sc;
   bit          m_prev_acc, m_prev_we;
   logic [13:0] m_addr;
   logic [7:0]  m_do, m_ardata, m_brdata;
   logic [7:0]  shadow [DEPTH];

   int n_vec = 0, n_miss = 0;
   logic       s_ag, s_bg, s_rd, s_wr, s_arv, s_brv;
   logic [7:0] s_ard, s_brd;

   function automatic in_t mk(bit rst, bit ar, bit aw, bit al, int aa, int ad,
                              bit br, bit bw, bit bl, int ba, int bd);
      in_t r;
      r.rst = rst;
      r.a_req = ar; r.a_we = aw; r.a_lock = al; r.a_addr = 14'(aa); r.a_wd = 8'(ad);
      r.b_req = br; r.b_we = bw; r.b_lock = bl; r.b_addr = 14'(ba); r.b_wd = 8'(bd);
      return r;
   endfunction

   function automatic vec_t mv(in_t s, bit ag, bit bg, bit rd, bit wr, bit arv, bit brv, int rdata);
      vec_t v;
      v.stim = s; v.e_ag = ag; v.e_bg = bg; v.e_rd = rd; v.e_wr = wr;
      v.e_arv = arv; v.e_brv = brv; v.e_rdata = 8'(rdata);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Grant decision from the arbitration rules
   function automatic void model_gnt(input in_t v, output bit ga, output bit gb, output bit idl);
      ga  = 1'b0;
      gb  = 1'b0;
      idl = !((m_owner == 1 && v.a_lock) || (m_owner == 2 && v.b_lock));
      if (v.rst) return;
      if (idl) begin
         if (v.b_req && (!v.a_req || m_starve >= int'(SM))) gb = 1'b1;
         else if (v.a_req) ga = 1'b1;
      end else if (m_owner == 1) ga = v.a_req;
      else gb = v.b_req;
   endfunction

   // Advance the model by one clock
   function automatic void model_commit(input in_t v, input bit ga, input bit gb, input bit idl);
      bit we; logic [13:0] ad; logic [7:0] wd;
      if (v.rst) begin
         m_owner = 0; m_starve = 0; m_prev_acc = 0; m_prev_we = 0;
         m_addr = '0; m_do = '0; m_ardata = '0; m_brdata = '0;
         m_sa = 0; m_sb = 0; m_sc = 0;
         m_pend.delete();
         cyc++;
         return;
      end
      if (m_pend.size() > 0) begin
         if (m_pend[0].due == cyc) begin
            if (m_pend[0].port) m_brdata = m_pend[0].data;
            else                m_ardata = m_pend[0].data;
            void'(m_pend.pop_front());
         end
      end
      m_prev_acc = ga || gb;
      m_prev_we  = 1'b0;
      if (ga || gb) begin
         we = gb ? v.b_we : v.a_we;
         ad = gb ? v.b_addr : v.a_addr;
         wd = gb ? v.b_wd : v.a_wd;
         m_prev_we = we; m_addr = ad; m_do = wd;
         if (we) shadow[ad] = wd;
         else    m_pend.push_back('{cyc + 2 + int'(RDL), gb, shadow[ad]});
      end
      if (gb) m_starve = 0;
      else if (idl && v.b_req && m_starve < 255) m_starve++;
      if (idl) m_owner = (gb && v.b_lock) ? 2 : (ga && v.a_lock) ? 1 : 0;
      if (ga && m_sa < 65535) m_sa++;
      if (gb && m_sb < 65535) m_sb++;
      if (v.a_req && v.b_req && m_sc < 65535) m_sc++;
      cyc++;
   endfunction

   // Drive one cycle, compare every output at the falling edge, then advance the model
   task automatic step(input in_t v);
      bit ga, gb, idl, rn, rport, ebusy;
      logic [7:0] ead, ebd;
      reset = v.rst;
      a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wd;
      b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wd;
      @(negedge clk);
      model_gnt(v, ga, gb, idl);
      rn = 1'b0; rport = 1'b0; ead = m_ardata; ebd = m_brdata; ebusy = (m_owner != 0);
      if (m_pend.size() > 0) begin
         rn    = (m_pend[0].due == cyc);
         rport = m_pend[0].port;
         if (rn && !rport) ead = m_pend[0].data;
         if (rn && rport)  ebd = m_pend[0].data;
         if (m_pend[m_pend.size()-1].due > cyc) ebusy = 1'b1;
      end
      chk("a_gnt",    32'(a_gnt),    32'(ga));
      chk("b_gnt",    32'(b_gnt),    32'(gb));
      chk("res_wr",   32'(res_wr),   32'(m_prev_acc && m_prev_we));
      chk("res_rd",   32'(res_rd),   32'(m_prev_acc && !m_prev_we));
      chk("res_addr", 32'(res_addr), 32'(m_addr));
      chk("res_do",   32'(res_do),   32'(m_do));
      chk("a_rvalid", 32'(a_rvalid), 32'(rn && !rport));
      chk("b_rvalid", 32'(b_rvalid), 32'(rn && rport));
      chk("a_rdata",  32'(a_rdata),  32'(ead));
      chk("b_rdata",  32'(b_rdata),  32'(ebd));
      chk("busy",     32'(busy),     32'(ebusy));
`ifdef ARB_STATS_EN
      chk("stat_a_gnt",    32'(stat_a_gnt),    32'(m_sa));
      chk("stat_b_gnt",    32'(stat_b_gnt),    32'(m_sb));
      chk("stat_conflict", 32'(stat_conflict), 32'(m_sc));
`else
      chk("stat_a_gnt",    32'(stat_a_gnt),    32'(0));
      chk("stat_b_gnt",    32'(stat_b_gnt),    32'(0));
      chk("stat_conflict", 32'(stat_conflict), 32'(0));
`endif
      s_ag = a_gnt; s_bg = b_gnt; s_rd = res_rd; s_wr = res_wr;
      s_arv = a_rvalid; s_brv = b_rvalid; s_ard = a_rdata; s_brd = b_rdata;
      @(posedge clk);
      model_commit(v, ga, gb, idl);
      #1;
   endtask

   initial begin
      vec_t        tbl[$];
      in_t         idle_v, rst_v;
      logic [13:0] burst [4];
      int          agc, bgc;

      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_val(i);
      idle_v = mk(0, 0,0,0,0,0, 0,0,0,0,0);
      rst_v  = mk(1, 1,0,0,0,0, 1,0,0,0,0);
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
      cyc = 0;
      @(posedge clk);
      model_commit(rst_v, 1'b0, 1'b0, 1'b1);
      #1;

      // Reset with both requesting, A first after release, B forced in on cycle 8,
      // B writes 0x0081=0x07 and A reads it back two cycles after acceptance
      for (int r = 0; r < 3; r++) tbl.push_back(mv(rst_v, 0,0,0,0,0,0, 0));
      for (int c = 0; c < 8; c++)
         tbl.push_back(mv(mk(0, 1,0,0,'h10+c,0, 1,1,0,'h81,'h07),
                          1,0, c >= 1, 0, c >= 2, 0, (c >= 2) ? int'(init_val('h10+c-2)) : 0));
      tbl.push_back(mv(mk(0, 1,0,0,'h18,0, 1,1,0,'h81,'h07), 0,1, 1,0, 1,0, int'(init_val('h16))));
      tbl.push_back(mv(mk(0, 1,0,0,'h81,0, 0,0,0,0,0),       1,0, 0,1, 1,0, int'(init_val('h17))));
      tbl.push_back(mv(idle_v, 0,0, 1,0, 0,0, 0));
      tbl.push_back(mv(idle_v, 0,0, 0,0, 1,0, 'h07));
      tbl.push_back(mv(idle_v, 0,0, 0,0, 0,0, 0));

      foreach (tbl[k]) begin
         step(tbl[k].stim);
         chk("tbl_a_gnt",    32'(s_ag),  32'(tbl[k].e_ag));
         chk("tbl_b_gnt",    32'(s_bg),  32'(tbl[k].e_bg));
         chk("tbl_res_rd",   32'(s_rd),  32'(tbl[k].e_rd));
         chk("tbl_res_wr",   32'(s_wr),  32'(tbl[k].e_wr));
         chk("tbl_a_rvalid", 32'(s_arv), 32'(tbl[k].e_arv));
         chk("tbl_b_rvalid", 32'(s_brv), 32'(tbl[k].e_brv));
         if (tbl[k].e_arv) chk("tbl_a_rdata", 32'(s_ard), 32'(tbl[k].e_rdata));
      end

      // Locked 4-read burst by A while B waits; B wins only once the lock drops
      burst[0] = 14'h0100; burst[1] = 14'h0101; burst[2] = 14'h0102; burst[3] = 14'h0181;
      agc = 0; bgc = 0;
      for (int k = 0; k < 21; k++) begin
         if (k < 4)       step(mk(0, 1,0,1,int'(burst[k]),0, 1,0,0,'h200,0));
         else if (k < 20) step(mk(0, 0,0,1,0,0,               1,0,0,'h200,0));
         else             step(mk(0, 0,0,0,0,0,               1,0,0,'h200,0));
         if (k < 20) begin
            agc += int'(s_ag);
            bgc += int'(s_bg);
         end
      end
      chk("lock_a_grants",  32'(agc),  32'(4));
      chk("lock_b_blocked", 32'(bgc),  32'(0));
      chk("lock_release_b", 32'(s_bg), 32'(1));
      for (int k = 0; k < 3; k++) step(idle_v);

      // Interleaved A read / B write / B read on consecutive cycles
      step(mk(0, 1,0,0,'h0005,0, 0,0,0,0,0));
      step(mk(0, 0,0,0,0,0,      1,1,0,'h0006,'h2A));
      step(mk(0, 0,0,0,0,0,      1,0,0,'h0006,0));
      chk("ilv_a_rvalid", 32'(s_arv), 32'(1));
      step(idle_v);
      chk("ilv_b_early",  32'(s_brv), 32'(0));
      step(idle_v);
      chk("ilv_b_rvalid", 32'(s_brv), 32'(1));
      chk("ilv_b_rdata",  32'(s_brd), 32'(8'h2A));
      step(idle_v);

      // Reset right after a B read is accepted kills the return
      step(mk(0, 0,0,0,0,0, 1,0,0,'h0006,0));
      step(mk(1, 0,0,0,0,0, 0,0,0,0,0));
      chk("rst_b_rvalid", 32'(s_brv), 32'(0));
      for (int k = 0; k < 4; k++) begin
         step(idle_v);
         if (k == 0) chk("rst_res_rd", 32'(s_rd), 32'(0));
         chk("rst_no_rvalid", 32'(s_brv), 32'(0));
      end

      // Randomized traffic on a small address window with occasional resets
      for (int k = 0; k < 2000; k++) begin
         in_t v;
         v = mk($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         step(v);
      end
      for (int k = 0; k < 4; k++) step(idle_v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
